sprite_cmd_scheduler: RTL
=========================

Name: sprite_cmd_scheduler

Overview:
- Sits between the Avalon write port and the shared 32-bit command bus that feeds every sprite display module (Bowser, Mario, tiles, and the rest).
- Buffers CPU command words in a FIFO and replays them onto the bus at one word per cycle.
- Holds every buffer-toggle command (action = 4'hF) until the start of vertical blank, so the active/inactive sprite buffers never swap mid-frame.
- Preserves command order.

Parameters:
- FIFO_DEPTH, 16, number of queued command words (power of 2).
- VBLANK_LINE, 480, vcount value that marks the start of vertical blank.
- IDLE_WORD, 32'h0000_0000, bus value when no command is issued; component ID 0 is reserved and matches no display module.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- write  in  1  Avalon write strobe.
- chipselect  in  1  Avalon chip select.
- writedata  in  32  command word: [31:26] component, [25:21] child, [20:17] action, [16:14] action_type, [13] buffer_toggle, [12:0] action_data.
- hcount  in  10  current pixel column from the VGA counter.
- vcount  in  10  current line from the VGA counter.
- clear_status  in  1  one-cycle pulse that clears the overflow flag.
- cmd_data  out  32  registered command bus to all display modules.
- fifo_full  out  1  FIFO holds FIFO_DEPTH words.
- pending  out  5  FIFO occupancy, 0..FIFO_DEPTH.
- overflow  out  1  sticky flag: a write was dropped.
- frame_count  out  8  count of issued buffer-toggle commands.

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; pending = 0.
  - FSM enters IDLE.
  - cmd_data = IDLE_WORD; overflow = 0; frame_count = 0.
  - Applies mid-operation too: queued words and any held flip are discarded.
- Accept rule:
  - A write is accepted when write & chipselect & !fifo_full.
  - fifo_full is evaluated on the pre-pop occupancy. A write while full is dropped even if a pop happens in the same cycle, and sets overflow.
- Overflow flag:
  - clear_status clears overflow.
  - If clear_status and a dropped write occur in the same cycle, overflow stays 1.
- vblank_start: one-cycle condition, true when vcount == VBLANK_LINE and hcount == 0.
- Flip word: a head word whose [20:17] == 4'hF.
- FSM state IDLE:
  - FIFO empty: cmd_data = IDLE_WORD.
  - Head is a non-flip word: pop it and register it onto cmd_data.
  - Head is a flip word and vblank_start is true: pop it, issue it, increment frame_count.
  - Head is a flip word and vblank_start is false: go to WAIT_VBLANK; cmd_data = IDLE_WORD.
- FSM state WAIT_VBLANK:
  - cmd_data = IDLE_WORD; no pops. Words behind the flip stay queued; writes are still accepted.
  - On vblank_start: pop and issue the flip, increment frame_count, return to IDLE.
- Issue timing:
  - A word appears on cmd_data for exactly one cycle; IDLE_WORD is driven every cycle no word is issued.
  - Back-to-back non-flip words issue on consecutive cycles.
  - At most one flip issues per vblank_start. A second queued flip waits for the next frame.
- Latency with an empty FIFO: a word sampled at rising edge k is driven on cmd_data from edge k+1 to edge k+2.
- Occupancy: simultaneous accept and pop leave pending unchanged.
- frame_count is 8 bits and wraps 255 -> 0.
- Unrelated command fields are passed through unmodified; the scheduler decodes only bits [20:17].

Test Plan:
- Reset, then 3 writes 0x2402_4005, 0x2404_8010, 0x2406_C020 on consecutive cycles -> each appears on cmd_data for one cycle, in order, one cycle after its write; IDLE_WORD otherwise; pending returns to 0.
- Write flip 0x241E_2000 at vcount = 100, then non-flip 0x2402_4005 -> cmd_data stays IDLE_WORD until vcount = 480/hcount = 0; then flip issues, next cycle 0x2402_4005 issues; frame_count = 1.
- Two flips queued -> first issues at line 480 of frame N, second at line 480 of frame N+1; frame_count advances by 1 per frame.
- 17 writes with no pops (held behind a waiting flip) -> fifo_full = 1 and pending = 16 after the 16th; the 17th is dropped and overflow = 1. clear_status pulse -> overflow = 0.
- Assert reset while in WAIT_VBLANK with pending = 5 -> next cycle pending = 0, cmd_data = IDLE_WORD, frame_count = 0; no flip issues at the following vblank.
- Preload frame_count to 255 via 255 single-flip frames, then one more flip -> frame_count wraps to 0.

Source files
------------

// File: rtl/sprite_cmd_scheduler.sv
// Command scheduler between the Avalon write port and the shared sprite command
// bus. CPU words are queued and replayed one per cycle. Buffer-toggle (flip)
// words are held until vertical blank starts, so sprite buffers only swap
// between frames.
module sprite_cmd_scheduler #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [9:0]  VBLANK_LINE = 10'd480,
  parameter logic [31:0] IDLE_WORD   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          write,
  input  logic                          chipselect,
  input  logic [31:0]                   writedata,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  input  logic                          clear_status,
  output logic [31:0]                   cmd_data,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          overflow,
  output logic [7:0]                    frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_WAIT_VBLANK} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cmd_q, cmd_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    frame_q, frame_d;

  logic [31:0]   head;
  logic          empty, full, head_flip, vblank_start, wr_req, push, drop, pop;

  // Next-state: accept/drop, FSM issue decision, pointer/occupancy/status update
  always_comb begin
    head         = mem_q[rd_ptr_q];
    empty        = (cnt_q == '0);
    full         = (cnt_q == CW'(FIFO_DEPTH));
    head_flip    = (head[20:17] == 4'hF);
    vblank_start = (vcount == VBLANK_LINE) && (hcount == 10'd0);
    wr_req       = write & chipselect;
    // full is judged on pre-pop occupancy: a same-cycle pop does not rescue a write
    push         = wr_req & ~full;
    drop         = wr_req & full;

    state_d = state_q;
    cmd_d   = IDLE_WORD;
    frame_d = frame_q;
    pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (!head_flip) begin
            pop   = 1'b1;
            cmd_d = head;
          end else if (vblank_start) begin
            pop     = 1'b1;
            cmd_d   = head;
            frame_d = frame_q + 8'd1;
          end else begin
            state_d = S_WAIT_VBLANK;
          end
        end
      end
      S_WAIT_VBLANK: begin
        // head is guaranteed to be the held flip; everything behind it waits
        if (vblank_start) begin
          pop     = 1'b1;
          cmd_d   = head;
          frame_d = frame_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    // a drop in the same cycle as clear_status wins so no loss goes unreported
    ovf_d    = drop ? 1'b1 : (clear_status ? 1'b0 : ovf_q);
  end

  // Control and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      cmd_q    <= IDLE_WORD;
      ovf_q    <= 1'b0;
      frame_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      ovf_q    <= ovf_d;
      frame_q  <= frame_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= writedata;
  end

  assign cmd_data    = cmd_q;
  assign fifo_full   = full;
  assign pending     = cnt_q;
  assign overflow    = ovf_q;
  assign frame_count = frame_q;

endmodule
